clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
Time-keeping core of the digital clock. It divides the system clock down to a 1 Hz tick and keeps hours, minutes and seconds as six BCD digits. A time-set mode lets front-panel pulses adjust minutes and hours. Each 4-bit digit output feeds one BCD-to-7-segment decoder instance directly downstream.

Parameters:
DIV, 50_000_000, system clock cycles per second; must be >= 2 (benches use 4)

Ports:
clk      in   1  system clock
rst      in   1  synchronous, active-high reset
set_en   in   1  time-set mode; level
inc_min  in   1  single-cycle pulse: add one minute (set mode only)
inc_hour in   1  single-cycle pulse: add one hour (set mode only)
tick     out  1  one-cycle pulse, once per second (colon blink / debug)
sec_lo   out  4  seconds units, BCD 0-9
sec_hi   out  4  seconds tens, BCD 0-5
min_lo   out  4  minutes units, BCD 0-9
min_hi   out  4  minutes tens, BCD 0-5
hr_lo    out  4  hours units, BCD 0-9 (0-3 when hr_hi=2)
hr_hi    out  4  hours tens, BCD 0-2

Behaviour:
- Clocking and reset: one clock domain (clk). rst is synchronous and active-high. It has priority over all other inputs.
- Reset values: prescaler=0, tick=0, all digit outputs=0 (time 00:00:00).
- Prescaler:
  - Width is clog2(DIV).
  - Counts 0..DIV-1 and wraps to 0.
  - tick is registered and is 1 in the cycle after the prescaler equals DIV-1, so the period is exactly DIV cycles.
- Run mode (set_en=0):
  - In the cycle tick is asserted, the time advances by one second; digits update on the next clock edge.
  - Carry chain: sec_lo 9->0 carries to sec_hi; sec_hi 5->0 carries to min_lo; min_lo carries to min_hi; min_hi 5->0 carries to hours.
  - Hours wrap 23 -> 00 (hr_lo 9->0 increments hr_hi; 23 -> 00 directly).
  - 23:59:59 -> 00:00:00 in a single update.
  - inc_min and inc_hour are ignored.
- Set mode (set_en=1):
  - Prescaler is held at 0 and tick stays 0.
  - Seconds are forced to 00 on every cycle.
  - inc_min: minutes +1, wrap 59 -> 00, no carry into hours.
  - inc_hour: hours +1, wrap 23 -> 00.
  - Both pulses in the same cycle: both apply independently.
  - A held pulse increments once per cycle; debouncing and edge detection are done upstream.
- Leaving set mode (set_en 1->0):
  - Prescaler restarts from 0.
  - The first tick occurs DIV cycles later, so one full second elapses before the first increment.
- Digit legality: no digit ever leaves its BCD range. The block never produces codes 10-15, so the downstream decoder default is never exercised.
- Reset mid-operation: the next edge gives 00:00:00 with prescaler 0, regardless of set_en or pending pulses.

Decomposition:
- Shared package `clock_pkg`:
  - BCD digit typedef (4 bits).
  - Constants SEC_HI_MAX=5, MIN_HI_MAX=5, HR_MAX_HI=2, HR_MAX_LO_AT_2=3.
- One natural sub-module, `bcd_mod_counter`:
  - A two-digit BCD counter with parameterised wrap value (59 or 23).
  - Ports: inc, clear, value outputs, and a carry pulse on wrap.
  - Instantiated three times: seconds, minutes, hours.
  - In set mode the minutes instance's carry output is not routed into hours.

Test Plan:
1. DIV=4, rst held 2 cycles, then released -> all digits 0; tick asserted every 4th cycle; after 10 ticks sec_hi=1, sec_lo=0.
2. Run 60 ticks from reset -> 00:01:00: min_lo=1, seconds 00, and no illegal digit at any cycle.
3. set_en=1, 23 inc_hour pulses and 59 inc_min pulses, set_en=0, then 1 tick -> 23:59:01. Next, preload 23:59:59 (set to 23:59, run 59 ticks) -> the following tick gives 00:00:00.
4. set_en=1, inc_min at 59 -> minutes=00, hours unchanged. Simultaneous inc_min+inc_hour from 05:10 -> 06:11.
5. Run mode, inc_min/inc_hour pulsed -> no change. Assert set_en mid-second -> seconds=00 next cycle, tick silent. Release -> first tick exactly 4 cycles later.
6. rst asserted at 12:34:56 with set_en=1 and inc_hour=1 in the same cycle -> 00:00:00, prescaler 0 on the next edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and digit limits for the digital clock time-keeping core.
// Each digit is a 4-bit BCD value that feeds a 7-segment decoder downstream.
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX        = 4'd9;
    localparam bcd_t SEC_HI_MAX     = 4'd5;
    localparam bcd_t MIN_HI_MAX     = 4'd5;
    localparam bcd_t HR_MAX_HI      = 4'd2;
    localparam bcd_t HR_MAX_LO_AT_2 = 4'd3;

endpackage

// File: rtl/clock_time_counter_if.sv
// Front-panel controls and BCD time digits of the clock core.
// The slave side is the counter core; the master side is the panel/display logic.
interface clock_time_counter_if;
    import clock_pkg::*;

    logic set_en;
    logic inc_min;
    logic inc_hour;
    logic tick;
    bcd_t sec_lo;
    bcd_t sec_hi;
    bcd_t min_lo;
    bcd_t min_hi;
    bcd_t hr_lo;
    bcd_t hr_hi;

    modport master (
        output set_en, inc_min, inc_hour,
        input  tick, sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi
    );

    modport slave (
        input  set_en, inc_min, inc_hour,
        output tick, sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from {WRAP_HI,WRAP_LO} to 00.
// carry is a combinational pulse in the cycle an increment causes the wrap.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd_t WRAP_HI = 4'd5,
    parameter bcd_t WRAP_LO = 4'd9
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clear,
    output bcd_t lo,
    output bcd_t hi,
    output logic carry
);

    logic at_wrap;

    assign at_wrap = (hi == WRAP_HI) && (lo == WRAP_LO);
    // Carry is combinational so a full ripple (23:59:59 -> 00:00:00) lands on one edge.
    assign carry   = inc && !clear && at_wrap;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lo <= '0;
            hi <= '0;
        end else if (inc) begin
            if (at_wrap) begin
                lo <= '0;
                hi <= '0;
            end else if (lo == BCD_MAX) begin
                lo <= '0;
                hi <= hi + 4'd1;
            end else begin
                lo <= lo + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_time_counter.sv
// Clock time-keeping core: DIV-cycle prescaler producing a 1 Hz tick and
// hh:mm:ss BCD counters with a set mode driven by front-panel pulses.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_time_counter_if.slave  bus
);

    localparam int              PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    logic [PW-1:0] presc;
    logic          tick_q;

    // Set mode parks the prescaler at 0 so leaving it gives a full second before the first tick.
    always_ff @(posedge clk) begin
        if (rst || bus.set_en) begin
            presc  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (presc == LAST);
            presc  <= (presc == LAST) ? '0 : presc + PW'(1);
        end
    end

    assign bus.tick = tick_q;

    logic sec_inc;
    logic sec_carry;
    logic min_inc;
    logic min_carry;
    logic hr_inc;
    logic hr_carry_unused;

    assign sec_inc = tick_q && !bus.set_en;
    // In set mode the pulses drive minutes and hours directly; the minute carry is dropped.
    assign min_inc = bus.set_en ? bus.inc_min  : sec_carry;
    assign hr_inc  = bus.set_en ? bus.inc_hour : min_carry;

    bcd_mod_counter #(.WRAP_HI(SEC_HI_MAX), .WRAP_LO(BCD_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .clear (bus.set_en),
        .lo    (bus.sec_lo),
        .hi    (bus.sec_hi),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.WRAP_HI(MIN_HI_MAX), .WRAP_LO(BCD_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .clear (1'b0),
        .lo    (bus.min_lo),
        .hi    (bus.min_hi),
        .carry (min_carry)
    );

    bcd_mod_counter #(.WRAP_HI(HR_MAX_HI), .WRAP_LO(HR_MAX_LO_AT_2)) u_hr (
        .clk   (clk),
        .rst   (rst),
        .inc   (hr_inc),
        .clear (1'b0),
        .lo    (bus.hr_lo),
        .hi    (bus.hr_hi),
        .carry (hr_carry_unused)
    );

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with DIV=4: an hh:mm:ss reference model
// pushes expected times into a scoreboard queue that is popped as the DUT updates.
module tb_clock_time_counter;
    import clock_pkg::*;

    localparam int DIV    = 4;
    localparam int BUDGET = 2 * DIV + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_time_counter_if bus ();

    clock_time_counter #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mh = 0;
    int mm = 0;
    int ms = 0;
    logic [23:0] exp_q [$];

    function automatic logic [23:0] enc(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] dut_time();
        return {bus.hr_hi, bus.hr_lo, bus.min_hi, bus.min_lo, bus.sec_hi, bus.sec_lo};
    endfunction

    function automatic logic legal();
        int h;
        h = int'(bus.hr_hi) * 10 + int'(bus.hr_lo);
        return (bus.sec_lo <= 4'd9) && (bus.sec_hi <= 4'd5) &&
               (bus.min_lo <= 4'd9) && (bus.min_hi <= 4'd5) &&
               (bus.hr_lo  <= 4'd9) && (bus.hr_hi  <= 4'd2) && (h <= 23);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic push_exp();
        exp_q.push_back(enc(mh, mm, ms));
    endtask

    task automatic pop_check(input string tag);
        logic [23:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check(tag, dut_time(), e);
    endtask

    task automatic adv_sec();
        ms++;
        if (ms == 60) begin ms = 0; mm++; end
        if (mm == 60) begin mm = 0; mh++; end
        if (mh == 24) mh = 0;
    endtask

    task automatic wait_tick(output int gap);
        gap = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clk);
            check("legal", legal(), 1);
            if (bus.tick === 1'b1) begin
                gap = i;
                break;
            end
        end
        if (gap == 0) check("tick_timeout", bus.tick, 1);
    endtask

    task automatic run_tick(input string tag, input int exp_gap);
        int gap;
        wait_tick(gap);
        check({tag, "_gap"}, gap, exp_gap);
        adv_sec();
        push_exp();
        @(negedge clk);
        check({tag, "_tick_low"}, bus.tick, 0);
        pop_check(tag);
    endtask

    task automatic run_ticks(input string tag, input int n, input int first_gap);
        for (int i = 0; i < n; i++)
            run_tick(tag, (i == 0) ? first_gap : DIV - 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mh = 0; mm = 0; ms = 0;
        push_exp();
        pop_check("reset_time");
        check("reset_tick", bus.tick, 0);
    endtask

    task automatic enter_set();
        bus.set_en = 1'b1;
        @(negedge clk);
        ms = 0;
        push_exp();
        pop_check("set_sec0");
        check("set_tick", bus.tick, 0);
    endtask

    task automatic set_pulse(input string tag, input bit m, input bit h, input int n);
        bus.inc_min  = m;
        bus.inc_hour = h;
        repeat (n) begin
            @(negedge clk);
            if (m) mm = (mm + 1) % 60;
            if (h) mh = (mh + 1) % 24;
        end
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;
        push_exp();
        pop_check(tag);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.set_en   = 1'b0;
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;

        // 1: reset, tick cadence, 10 seconds
        do_reset();
        run_ticks("t1_sec", 10, DIV);
        check("t1_sec10", dut_time(), enc(0, 0, 10));

        // 2: up to one minute, legality sampled every cycle
        run_ticks("t2_sec", 50, DIV - 1);
        check("t2_min1", dut_time(), enc(0, 1, 0));

        // 3: set 23:59, run to 23:59:59, then full wrap
        do_reset();
        enter_set();
        set_pulse("t3_hours", 1'b0, 1'b1, 23);
        set_pulse("t3_mins", 1'b1, 1'b0, 59);
        bus.set_en = 1'b0;
        run_tick("t3_first", DIV);
        check("t3_235901", dut_time(), enc(23, 59, 1));
        run_ticks("t3_run", 58, DIV - 1);
        run_tick("t3_wrap", DIV - 1);
        check("t3_000000", dut_time(), enc(0, 0, 0));

        // 4: minute wrap without hour carry, simultaneous pulses
        enter_set();
        set_pulse("t4_h5", 1'b0, 1'b1, 5);
        set_pulse("t4_m59", 1'b1, 1'b0, 59);
        set_pulse("t4_mwrap", 1'b1, 1'b0, 1);
        check("t4_0500", dut_time(), enc(5, 0, 0));
        set_pulse("t4_m10", 1'b1, 1'b0, 10);
        set_pulse("t4_both", 1'b1, 1'b1, 1);
        check("t4_0611", dut_time(), enc(6, 11, 0));

        // 5: pulses ignored in run mode, set mid-second, release timing
        bus.set_en   = 1'b0;
        bus.inc_min  = 1'b1;
        bus.inc_hour = 1'b1;
        @(negedge clk);
        bus.inc_min  = 1'b0;
        bus.inc_hour = 1'b0;
        @(negedge clk);
        push_exp();
        pop_check("t5_ignored");
        run_tick("t5_tick", DIV - 2);
        enter_set();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_tick_silent", bus.tick, 0);
        end
        bus.set_en = 1'b0;
        run_tick("t5_release", DIV);

        // 6: reset at 12:34:56 with set_en and inc_hour active
        enter_set();
        set_pulse("t6_h12", 1'b0, 1'b1, 6);
        set_pulse("t6_m34", 1'b1, 1'b0, 23);
        bus.set_en = 1'b0;
        run_ticks("t6_run", 56, DIV);
        check("t6_123456", dut_time(), enc(12, 34, 56));
        rst          = 1'b1;
        bus.set_en   = 1'b1;
        bus.inc_hour = 1'b1;
        @(negedge clk);
        mh = 0; mm = 0; ms = 0;
        push_exp();
        pop_check("t6_reset");
        check("t6_reset_tick", bus.tick, 0);
        rst          = 1'b0;
        bus.set_en   = 1'b0;
        bus.inc_hour = 1'b0;
        run_tick("t6_presc0", DIV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
